// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller: FSM encodings and
// the predictor-update entry layout.
package branch_redirect_ctrl_pkg;

    localparam int PC_W = 32;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } upd_entry_t;

    localparam int UPD_W = $bits(upd_entry_t);

    function automatic logic [PC_W-1:0] resolved_pc(input logic            taken,
                                                    input logic [PC_W-1:0] pc,
                                                    input logic [PC_W-1:0] target);
        return taken ? target : pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_upd_fifo.sv
// Circular 2-write/1-read FIFO for predictor updates; the pop of the current
// cycle frees space for this cycle's writes.
module upd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 65
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        push_req,
    input  logic [1:0][W-1:0] push_data,
    output logic [1:0]        push_ok,
    output logic              rd_valid,
    output logic [W-1:0]      rd_data,
    input  logic              rd_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, used, space;
    logic [AW-1:0]   wr_idx0, wr_idx1;
    logic [1:0]      n_acc;
    logic [W-1:0]    first;
    logic            pop;

    assign used     = wr_ptr - rd_ptr;
    assign rd_valid = (used != '0);
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign pop      = rd_valid & rd_ready;
    assign space    = PW'(DEPTH) - used + PW'(pop);

    // Lane 0 claims the first free slot, so lane 1 is the one dropped.
    always_comb begin
        push_ok = '0;
        if (push_req[0]) begin
            push_ok[0] = (space != '0);
            push_ok[1] = push_req[1] && (space >= PW'(2));
        end else begin
            push_ok[1] = push_req[1] && (space != '0);
        end
    end

    assign n_acc   = {1'b0, push_ok[0]} + {1'b0, push_ok[1]};
    assign first   = push_ok[0] ? push_data[0] : push_data[1];
    assign wr_idx0 = wr_ptr[AW-1:0];
    assign wr_idx1 = wr_idx0 + AW'(1);

    always_ff @(posedge clk) begin
        if (n_acc != 2'd0) mem[wr_idx0] <= first;
        if (n_acc == 2'd2) mem[wr_idx1] <= push_data[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_acc);
            rd_ptr <= rd_ptr + PW'(pop);
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Detects mispredicts from two execute lanes, issues the oldest as a frontend
// redirect with a one-cycle flush, and queues predictor-training updates.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int UPD_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           br_valid,
    input  logic [1:0][PC_W-1:0] br_pc,
    input  logic [1:0]           br_taken,
    input  logic [1:0][PC_W-1:0] br_target,
    input  logic [1:0]           br_pred_taken,
    input  logic [1:0][PC_W-1:0] br_pred_target,
    output logic                 redirect_valid,
    output logic [PC_W-1:0]      redirect_pc,
    input  logic                 redirect_ready,
    output logic                 flush,
    output logic                 stall,
    output logic                 upd_valid,
    output logic [PC_W-1:0]      upd_pc,
    output logic [PC_W-1:0]      upd_target,
    output logic                 upd_taken,
    input  logic                 upd_ready,
    output logic [15:0]          upd_drop_cnt
);
    logic [0:0]              state;
    logic                    idle;
    logic [1:0]              mis;
    logic [1:0][PC_W-1:0]    corr;
    logic [1:0]              push_req, push_ok;
    logic [1:0][UPD_W-1:0]   push_data;
    logic [UPD_W-1:0]        rd_data;
    upd_entry_t              head;
    logic [1:0]              drops;
    logic [16:0]             drop_sum;

    assign idle = (state == IDLE);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mis[i] = br_valid[i] & ((br_taken[i] != br_pred_taken[i]) |
                                    (br_taken[i] & (br_target[i] != br_pred_target[i])));
            corr[i]      = resolved_pc(br_taken[i], br_pc[i], br_target[i]);
            push_data[i] = {br_pc[i], br_taken[i], br_target[i]};
        end
    end

    // A lane-0 mispredict makes lane 1 wrong-path; in WAIT everything is.
    assign push_req = {idle & br_valid[1] & ~mis[0], idle & br_valid[0]};

    upd_fifo #(.DEPTH(UPD_DEPTH), .W(UPD_W)) u_upd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_req  (push_req),
        .push_data (push_data),
        .push_ok   (push_ok),
        .rd_valid  (upd_valid),
        .rd_data   (rd_data),
        .rd_ready  (upd_ready)
    );

    assign head       = upd_entry_t'(rd_data);
    assign upd_pc     = head.pc;
    assign upd_taken  = head.taken;
    assign upd_target = head.target;

    assign drops    = {1'b0, push_req[0] & ~push_ok[0]} + {1'b0, push_req[1] & ~push_ok[1]};
    assign drop_sum = {1'b0, upd_drop_cnt} + 17'(drops);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            redirect_pc  <= '0;
            flush        <= 1'b0;
            upd_drop_cnt <= '0;
        end else begin
            flush        <= 1'b0;
            upd_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (state == IDLE) begin
                if (|mis) begin
                    state       <= WAIT;
                    flush       <= 1'b1;
                    redirect_pc <= mis[0] ? corr[0] : corr[1];
                end
            end else if (redirect_ready) begin
                state <= IDLE;
            end
        end
    end

    assign redirect_valid = (state == WAIT);
    assign stall          = (state == WAIT);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: redirect checks inline per
// test, predictor updates checked against a scoreboard queue on every pop.
module tb_branch_redirect_ctrl;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    logic             clk, rst;
    logic [1:0]       br_valid, br_taken, br_pred_taken;
    logic [1:0][31:0] br_pc, br_target, br_pred_target;
    logic             redirect_valid, redirect_ready, flush, stall;
    logic [31:0]      redirect_pc, upd_pc, upd_target;
    logic             upd_valid, upd_taken, upd_ready;
    logic [15:0]      upd_drop_cnt;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    logic m_wait;
    logic [15:0] m_drop;

    branch_redirect_ctrl #(.UPD_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .br_valid(br_valid), .br_pc(br_pc), .br_taken(br_taken), .br_target(br_target),
        .br_pred_taken(br_pred_taken), .br_pred_target(br_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .flush(flush), .stall(stall),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_ready(upd_ready), .upd_drop_cnt(upd_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && upd_valid && upd_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL upd_extra: got pc=%h with no entry expected", upd_pc);
            end else begin
                ent_t e;
                e = q.pop_front();
                if ({upd_pc, upd_taken, upd_target} !== e) begin
                    errors++;
                    $display("FAIL upd_entry: got %h/%b/%h want %h/%b/%h",
                             upd_pc, upd_taken, upd_target, e.pc, e.taken, e.target);
                end
            end
        end
    end

    task automatic set_lane(input int i, input logic v, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
        br_valid[i] = v; br_pc[i] = pc; br_taken[i] = tk; br_target[i] = tgt;
        br_pred_taken[i] = ptk; br_pred_target[i] = ptgt;
    endtask

    task automatic clr_lanes();
        br_valid = '0; br_pc = '0; br_taken = '0; br_target = '0;
        br_pred_taken = '0; br_pred_target = '0;
    endtask

    task automatic model_reset();
        q.delete();
        m_wait = 1'b0;
        m_drop = '0;
    endtask

    // Advances one clock; beforehand, predicts pushes/drops/FSM from current inputs.
    task automatic tick();
        logic mis [2];
        int   space;
        space = DEPTH - q.size() + ((upd_ready && q.size() > 0) ? 1 : 0);
        for (int i = 0; i < 2; i++)
            mis[i] = br_valid[i] && ((br_taken[i] != br_pred_taken[i]) ||
                                     (br_taken[i] && br_target[i] != br_pred_target[i]));
        if (!m_wait) begin
            for (int i = 0; i < 2; i++) begin
                if (br_valid[i] && !(i == 1 && mis[0])) begin
                    if (space > 0) begin
                        q.push_back({br_pc[i], br_taken[i], br_target[i]});
                        space--;
                    end else if (m_drop != 16'hFFFF) begin
                        m_drop++;
                    end
                end
            end
            if (mis[0] || mis[1]) m_wait = 1'b1;
        end else if (redirect_ready) begin
            m_wait = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr_lanes(); redirect_ready = 1'b0; upd_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks += 6;
        if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_rv: got %b want 0", redirect_valid); end
        if (flush !== 1'b0)          begin errors++; $display("FAIL rst_flush: got %b want 0", flush); end
        if (stall !== 1'b0)          begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
        if (upd_valid !== 1'b0)      begin errors++; $display("FAIL rst_upd_valid: got %b want 0", upd_valid); end
        if (redirect_pc !== 32'h0)   begin errors++; $display("FAIL rst_rpc: got %h want 0", redirect_pc); end
        if (upd_drop_cnt !== 16'h0)  begin errors++; $display("FAIL rst_drop: got %h want 0", upd_drop_cnt); end
    endtask

    task automatic drain(input int n);
        upd_ready = 1'b1;
        repeat (n) tick();
        checks++;
        if (upd_valid !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL drain: got upd_valid=%b want 0 (%0d entries never seen)", upd_valid, q.size());
        end
    endtask

    task automatic test_mispredict_lane0();
        upd_ready = 1'b0; redirect_ready = 1'b1;
        set_lane(0, 1, 32'h1c000100, 1, 32'h1c000200, 0, 32'h0);
        tick(); clr_lanes();
        checks += 5;
        if (redirect_valid !== 1'b1)      begin errors++; $display("FAIL l0_rv: got %b want 1", redirect_valid); end
        if (redirect_pc !== 32'h1c000200) begin errors++; $display("FAIL l0_rpc: got %h want 1c000200", redirect_pc); end
        if (flush !== 1'b1)               begin errors++; $display("FAIL l0_flush: got %b want 1", flush); end
        if (stall !== 1'b1)               begin errors++; $display("FAIL l0_stall: got %b want 1", stall); end
        if (upd_valid !== 1'b1 || upd_pc !== 32'h1c000100)
            begin errors++; $display("FAIL l0_upd_head: got %b/%h want 1/1c000100", upd_valid, upd_pc); end
        tick();
        checks += 2;
        if (redirect_valid !== 1'b0 || stall !== 1'b0)
            begin errors++; $display("FAIL l0_rv_drop: got %b/%b want 0/0", redirect_valid, stall); end
        if (flush !== 1'b0) begin errors++; $display("FAIL l0_flush_len: got %b want 0", flush); end
        drain(3);
    endtask

    task automatic test_both_lanes();
        upd_ready = 1'b0; redirect_ready = 1'b1;
        set_lane(0, 1, 32'h1c000010, 0, 32'h1c000080, 1, 32'h1c000080);
        set_lane(1, 1, 32'h1c000014, 1, 32'h1c000300, 0, 32'h0);
        tick(); clr_lanes();
        checks += 2;
        if (redirect_pc !== 32'h1c000014) begin errors++; $display("FAIL both_rpc: got %h want 1c000014", redirect_pc); end
        if (upd_pc !== 32'h1c000010 || upd_taken !== 1'b0)
            begin errors++; $display("FAIL both_head: got %h/%b want 1c000010/0", upd_pc, upd_taken); end
        tick();
        drain(3);
    endtask

    task automatic test_hold();
        upd_ready = 1'b1; redirect_ready = 1'b0;
        set_lane(0, 1, 32'h1c000400, 1, 32'h1c000800, 0, 32'h0);
        tick();
        for (int k = 0; k < 5; k++) begin
            set_lane(0, 1, 32'h1c000500 + 32'(k*8), 1, 32'h1c000900, 0, 32'h0);
            set_lane(1, 1, 32'h1c000504 + 32'(k*8), 0, 32'h0, 1, 32'h1c000a00);
            tick();
            checks++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c000800 || stall !== 1'b1 || flush !== 1'b0)
                begin errors++; $display("FAIL hold_%0d: got rv=%b rpc=%h stall=%b flush=%b want 1/1c000800/1/0",
                                         k, redirect_valid, redirect_pc, stall, flush); end
        end
        clr_lanes();
        checks++;
        if (upd_valid !== 1'b0) begin errors++; $display("FAIL hold_nopush: got upd_valid=%b want 0", upd_valid); end
        redirect_ready = 1'b1;
        tick();
        checks++;
        if (redirect_valid !== 1'b0 || stall !== 1'b0)
            begin errors++; $display("FAIL hold_release: got %b/%b want 0/0", redirect_valid, stall); end
        drain(2);
    endtask

    task automatic test_fifo_drop();
        logic [15:0] d0;
        d0 = upd_drop_cnt;
        upd_ready = 1'b0; redirect_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_lane(0, 1, 32'h1c001000 + 32'(k*16), 0, 32'h1c00f000, 0, 32'h1c00e000);
            set_lane(1, 1, 32'h1c001004 + 32'(k*16), 1, 32'h1c002000 + 32'(k), 1, 32'h1c002000 + 32'(k));
            tick();
        end
        clr_lanes();
        checks += 3;
        if (upd_drop_cnt !== d0 + 16'd2) begin errors++; $display("FAIL drop_cnt: got %0d want %0d", upd_drop_cnt, d0 + 16'd2); end
        if (upd_drop_cnt !== m_drop)     begin errors++; $display("FAIL drop_model: got %0d want %0d", upd_drop_cnt, m_drop); end
        if (redirect_valid !== 1'b0)     begin errors++; $display("FAIL drop_norv: got %b want 0", redirect_valid); end
        // Full FIFO with a pop: lane 0 takes the freed slot, lane 1 is dropped.
        upd_ready = 1'b1;
        set_lane(0, 1, 32'h1c003000, 0, 32'h0, 0, 32'h0);
        set_lane(1, 1, 32'h1c003004, 0, 32'h0, 0, 32'h0);
        tick(); clr_lanes();
        checks++;
        if (upd_drop_cnt !== d0 + 16'd3) begin errors++; $display("FAIL full_pop_drop: got %0d want %0d", upd_drop_cnt, d0 + 16'd3); end
        drain(6);
    endtask

    task automatic test_back_to_back();
        upd_ready = 1'b1; redirect_ready = 1'b1;
        set_lane(0, 1, 32'h1c004000, 0, 32'h0, 0, 32'h0);
        set_lane(1, 1, 32'h1c004004, 0, 32'h1c004100, 1, 32'h1c004100);
        tick();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c004008)
            begin errors++; $display("FAIL b2b_a: got %b/%h want 1/1c004008", redirect_valid, redirect_pc); end
        clr_lanes();
        set_lane(0, 1, 32'h1c005000, 1, 32'h1c006000, 1, 32'h1c006004);
        tick();
        checks++;
        if (redirect_valid !== 1'b0 || flush !== 1'b0)
            begin errors++; $display("FAIL b2b_gap: got %b/%b want 0/0", redirect_valid, flush); end
        tick();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c006000 || flush !== 1'b1)
            begin errors++; $display("FAIL b2b_b: got %b/%h/%b want 1/1c006000/1", redirect_valid, redirect_pc, flush); end
        clr_lanes();
        tick();
        drain(4);
    endtask

    task automatic test_reset_in_wait();
        upd_ready = 1'b0; redirect_ready = 1'b0;
        set_lane(0, 1, 32'h1c007000, 1, 32'h1c007800, 0, 32'h0);
        tick(); clr_lanes();
        checks++;
        if (redirect_valid !== 1'b1 || upd_valid !== 1'b1)
            begin errors++; $display("FAIL rw_pre: got %b/%b want 1/1", redirect_valid, upd_valid); end
        #2 rst = 1'b1;
        #1;
        checks += 2;
        if (redirect_valid !== 1'b0 || stall !== 1'b0 || redirect_pc !== 32'h0)
            begin errors++; $display("FAIL rw_abort: got %b/%b/%h want 0/0/0", redirect_valid, stall, redirect_pc); end
        if (upd_valid !== 1'b0) begin errors++; $display("FAIL rw_fifo: got %b want 0", upd_valid); end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        redirect_ready = 1'b1; upd_ready = 1'b1;
        set_lane(1, 1, 32'h1c008000, 0, 32'h0, 1, 32'h1c008800);
        tick(); clr_lanes();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1c008004 || flush !== 1'b1)
            begin errors++; $display("FAIL rw_after: got %b/%h/%b want 1/1c008004/1", redirect_valid, redirect_pc, flush); end
        tick();
        drain(2);
    endtask

    initial begin
        test_reset();
        test_mispredict_lane0();
        test_both_lanes();
        test_hold();
        test_fifo_drop();
        test_back_to_back();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
